// File: rtl/calc2_pkg.sv
// Shared types for the calc2 scheduler: command encodings, unit classes, in-flight record.
// Pure declarations and one combinational helper; no state, no latency, no flow control.
package calc2_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ADD,
        CLS_SHF,
        CLS_INV
    } class_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] port;
        logic [1:0] tag;
    } inflight_t;

    function automatic class_t cmd_class(input logic [3:0] cmd);
        class_t cls;
        case (cmd)
            CMD_NOP:          cls = CLS_NONE;
            CMD_ADD, CMD_SUB: cls = CLS_ADD;
            CMD_SHL, CMD_SHR: cls = CLS_SHF;
            default:          cls = CLS_INV;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/calc2_rr_pick.sv
// Round-robin picker: first set bit of elig at or after ptr, wrapping 3 -> 0.
// Purely combinational, zero latency; no flow control (caller owns the pointer register).
// Backpressure: none, found=0 simply means nothing to grant this cycle.
module calc2_rr_pick (
    input  logic [3:0] elig,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);
    import calc2_pkg::*;

    // Scan from the farthest offset down so the closest candidate to ptr is the last writer.
    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[ptr + 2'(i)]) begin
                found = 1'b1;
                idx   = ptr + 2'(i);
            end
        end
    end

endmodule

// File: rtl/calc2_rr_sched.sv
// Round-robin scheduler of four hold-register ports onto the shared adder and shifter.
// Grant/ack/invalid registered one edge after the request; results flagged ALU_LAT cycles after grant.
// Backpressure: requests hold until req_ack; a busy {port,tag} stalls until its result retires.
module calc2_rr_sched
    import calc2_pkg::*;
#(
    parameter int NPORTS  = 4,
    parameter int TAGW    = 2,
    parameter int ALU_LAT = 3
) (
    input  logic                   c_clk,
    input  logic                   reset,
    input  logic [4*NPORTS-1:0]    req_cmd,
    input  logic [TAGW*NPORTS-1:0] req_tag,
    output logic [NPORTS-1:0]      req_ack,
    output logic                   add_vld,
    output logic [3:0]             add_cmd,
    output logic [1:0]             add_sel,
    output logic                   shf_vld,
    output logic [3:0]             shf_cmd,
    output logic [1:0]             shf_sel,
    output logic                   add_out_vld,
    output logic [3:0]             add_out_tag,
    output logic                   shf_out_vld,
    output logic [3:0]             shf_out_tag,
    output logic [NPORTS-1:0]      invalid_op,
    output logic [TAGW*NPORTS-1:0] invalid_tag
);

    logic [NPORTS-1:0][(1<<TAGW)-1:0] sb;
    logic [1:0]             add_ptr, shf_ptr;
    logic [TAGW-1:0]        add_tag_q, shf_tag_q;
    inflight_t              add_pipe [ALU_LAT];
    inflight_t              shf_pipe [ALU_LAT];

    class_t                 cls;
    logic [TAGW-1:0]        tg;
    logic [NPORTS-1:0]      elig_add, elig_shf, inv_now, ack_nxt;
    logic [TAGW*NPORTS-1:0] itag_nxt;
    logic                   add_found, shf_found;
    logic [1:0]             add_win, shf_win;

    // A port that is still seeing its own ack has not withdrawn yet, so it is masked.
    always_comb begin
        elig_add = '0;
        elig_shf = '0;
        inv_now  = '0;
        itag_nxt = '0;
        cls      = CLS_NONE;
        tg       = '0;
        for (int p = 0; p < NPORTS; p++) begin
            cls = cmd_class(req_cmd[4*p +: 4]);
            tg  = req_tag[TAGW*p +: TAGW];
            elig_add[p] = (cls == CLS_ADD) && !sb[p][tg] && !req_ack[p];
            elig_shf[p] = (cls == CLS_SHF) && !sb[p][tg] && !req_ack[p];
            inv_now[p]  = (cls == CLS_INV) && !req_ack[p];
            if (inv_now[p])
                itag_nxt[TAGW*p +: TAGW] = tg;
        end
    end

    calc2_rr_pick u_add_pick (.elig(elig_add), .ptr(add_ptr), .found(add_found), .idx(add_win));
    calc2_rr_pick u_shf_pick (.elig(elig_shf), .ptr(shf_ptr), .found(shf_found), .idx(shf_win));

    always_comb begin
        ack_nxt = inv_now;
        if (add_found) ack_nxt[add_win] = 1'b1;
        if (shf_found) ack_nxt[shf_win] = 1'b1;
    end

    assign add_out_vld = add_pipe[ALU_LAT-1].vld;
    assign add_out_tag = {add_pipe[ALU_LAT-1].port, add_pipe[ALU_LAT-1].tag};
    assign shf_out_vld = shf_pipe[ALU_LAT-1].vld;
    assign shf_out_tag = {shf_pipe[ALU_LAT-1].port, shf_pipe[ALU_LAT-1].tag};

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            sb          <= '0;
            add_ptr     <= '0;
            shf_ptr     <= '0;
            add_vld     <= 1'b0;
            add_cmd     <= '0;
            add_sel     <= '0;
            add_tag_q   <= '0;
            shf_vld     <= 1'b0;
            shf_cmd     <= '0;
            shf_sel     <= '0;
            shf_tag_q   <= '0;
            req_ack     <= '0;
            invalid_op  <= '0;
            invalid_tag <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                add_pipe[k] <= '0;
                shf_pipe[k] <= '0;
            end
        end else begin
            add_vld     <= add_found;
            add_cmd     <= add_found ? req_cmd[{add_win, 2'b00} +: 4] : 4'd0;
            add_sel     <= add_found ? add_win : 2'd0;
            add_tag_q   <= add_found ? req_tag[TAGW*add_win +: TAGW] : '0;
            shf_vld     <= shf_found;
            shf_cmd     <= shf_found ? req_cmd[{shf_win, 2'b00} +: 4] : 4'd0;
            shf_sel     <= shf_found ? shf_win : 2'd0;
            shf_tag_q   <= shf_found ? req_tag[TAGW*shf_win +: TAGW] : '0;
            req_ack     <= ack_nxt;
            invalid_op  <= inv_now;
            invalid_tag <= itag_nxt;
            if (add_found) add_ptr <= add_win + 2'd1;
            if (shf_found) shf_ptr <= shf_win + 2'd1;

            add_pipe[0] <= '{vld: add_vld, port: add_sel, tag: add_tag_q};
            shf_pipe[0] <= '{vld: shf_vld, port: shf_sel, tag: shf_tag_q};
            for (int k = 1; k < ALU_LAT; k++) begin
                add_pipe[k] <= add_pipe[k-1];
                shf_pipe[k] <= shf_pipe[k-1];
            end

            // Sets first, clears last: a same-entry collision resolves to cleared.
            if (add_found) sb[add_win][req_tag[TAGW*add_win +: TAGW]] <= 1'b1;
            if (shf_found) sb[shf_win][req_tag[TAGW*shf_win +: TAGW]] <= 1'b1;
            if (add_out_vld) sb[add_out_tag[3:2]][add_out_tag[1:0]] <= 1'b0;
            if (shf_out_vld) sb[shf_out_tag[3:2]][shf_out_tag[1:0]] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc2_rr_sched.sv
// Bench for calc2_rr_sched: reset/vector table, directed multi-cycle sequences, then
// randomized requesters checked against a cycle-level reference model.
module tb_calc2_rr_sched;
    localparam int L  = 3;
    localparam int NQ = 4096;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req_cmd = '0;
    logic [7:0]  req_tag = '0;
    logic [3:0]  req_ack, invalid_op;
    logic [7:0]  invalid_tag;
    logic        add_vld, shf_vld, add_out_vld, shf_out_vld;
    logic [3:0]  add_cmd, shf_cmd, add_out_tag, shf_out_tag;
    logic [1:0]  add_sel, shf_sel;

    calc2_rr_sched #(.NPORTS(4), .TAGW(2), .ALU_LAT(L)) dut (
        .c_clk(c_clk), .reset(reset), .req_cmd(req_cmd), .req_tag(req_tag),
        .req_ack(req_ack), .add_vld(add_vld), .add_cmd(add_cmd), .add_sel(add_sel),
        .shf_vld(shf_vld), .shf_cmd(shf_cmd), .shf_sel(shf_sel),
        .add_out_vld(add_out_vld), .add_out_tag(add_out_tag),
        .shf_out_vld(shf_out_vld), .shf_out_tag(shf_out_tag),
        .invalid_op(invalid_op), .invalid_tag(invalid_tag)
    );

    always #5 c_clk = ~c_clk;

    int total = 0;
    int bad   = 0;

    wire [39:0] obs = {add_vld, add_cmd, add_sel, shf_vld, shf_cmd, shf_sel, req_ack,
                       invalid_op, invalid_tag, add_out_vld, add_out_tag, shf_out_vld, shf_out_tag};

    function automatic logic [39:0] pk(input logic av, input logic [3:0] ac, input logic [1:0] as_,
                                       input logic sv, input logic [3:0] sc, input logic [1:0] ss,
                                       input logic [3:0] ack, input logic [3:0] inv, input logic [7:0] itag,
                                       input logic aov, input logic [3:0] aot,
                                       input logic sov, input logic [3:0] sot);
        return {av, ac, as_, sv, sc, ss, ack, inv, itag, aov, aot, sov, sot};
    endfunction

    task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge c_clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        req_cmd = '0;
        req_tag = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int cls_of(input logic [3:0] c);
        if (c == 4'd0) return 0;
        if (c == 4'd1 || c == 4'd2) return 1;
        if (c == 4'd5 || c == 4'd6) return 2;
        return 3;
    endfunction

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  tag;
        logic [39:0] exp;
    } vec_t;
    vec_t vt[6];

    // Reference model state for the random phase
    int         busy_until [16];
    int         ptr_a, ptr_s;
    logic [4:0] aq [NQ];
    logic [4:0] sq [NQ];
    logic [3:0] ack_prev;
    logic [3:0] rc [4];
    logic [1:0] rt [4];

    initial begin
        int gk, gcmd, outk, cnt;
        logic [1:0] ptag [4];

        vt[0] = '{16'h0100, 8'h10, pk(1, 4'd1, 2'd2, 0, 4'd0, 2'd0, 4'b0100, 4'b0000, 8'h00, 0, 4'd0, 0, 4'd0)};
        vt[1] = '{16'h6611, 8'h00, pk(1, 4'd1, 2'd0, 1, 4'd6, 2'd2, 4'b0101, 4'b0000, 8'h00, 0, 4'd0, 0, 4'd0)};
        vt[2] = '{16'hF000, 8'h80, pk(0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 4'b1000, 4'b1000, 8'h80, 0, 4'd0, 0, 4'd0)};
        vt[3] = '{16'h8743, 8'hE4, pk(0, 4'd0, 2'd0, 0, 4'd0, 2'd0, 4'b1111, 4'b1111, 8'hE4, 0, 4'd0, 0, 4'd0)};
        vt[4] = '{16'h2050, 8'hC4, pk(1, 4'd2, 2'd3, 1, 4'd5, 2'd1, 4'b1010, 4'b0000, 8'h00, 0, 4'd0, 0, 4'd0)};
        vt[5] = '{16'h0921, 8'h20, pk(1, 4'd1, 2'd0, 0, 4'd0, 2'd0, 4'b0101, 4'b0100, 8'h20, 0, 4'd0, 0, 4'd0)};

        do_reset();
        chk("reset_state", obs, 40'd0);

        foreach (vt[i]) begin
            do_reset();
            req_cmd = vt[i].cmd;
            req_tag = vt[i].tag;
            tick();
            chk($sformatf("vec%0d", i), obs, vt[i].exp);
            req_cmd = '0;
            req_tag = '0;
        end

        // Result latency: port 2 ADD tag 1
        do_reset();
        req_cmd = 16'h0100;
        req_tag = 8'h10;
        tick();
        req_cmd = '0;
        req_tag = '0;
        for (int k = 1; k <= L; k++) begin
            tick();
            chk($sformatf("lat_k%0d", k), obs,
                (k == L) ? pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1001, 0, 0) : 40'd0);
        end

        // Continuous all-port ADD: order 0,1,2,3,0, fresh tag after each ack
        do_reset();
        for (int p = 0; p < 4; p++) ptag[p] = 2'd0;
        req_cmd = 16'h1111;
        req_tag = 8'h00;
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % 4;
            tick();
            chk($sformatf("rr_n%0d", n), {33'd0, add_vld, add_sel, req_ack},
                {33'd0, 1'b1, 2'(e), 4'(1 << e)});
            ptag[e] = ptag[e] + 2'd1;
            req_tag[2*e +: 2] = ptag[e];
        end
        req_cmd = '0;

        // Same {port,tag} reuse stalls until the first result retires
        do_reset();
        req_cmd = 16'h0001;
        req_tag = 8'h00;
        tick();
        chk("stall_first", {33'd0, add_vld, add_cmd, add_sel}, {33'd0, 1'b1, 4'd1, 2'd0});
        req_cmd = 16'h0002;
        gk = 0; gcmd = 0; outk = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (add_out_vld && outk == 0) outk = k;
            if (add_vld && gk == 0) begin
                gk = k;
                gcmd = int'(add_cmd);
                req_cmd = '0;
            end
        end
        chk("stall_out_k", 40'(outk), 40'(L));
        chk("stall_grant_k", 40'(gk), 40'(L + 2));
        chk("stall_cmd", 40'(gcmd), 40'd2);

        // Reset while a result is in flight
        do_reset();
        req_cmd = 16'h0010;
        tick();
        chk("rst_grant", obs, pk(1, 4'd1, 2'd1, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
        req_cmd = '0;
        tick();
        reset = 1'b1;
        #1;
        chk("rst_async", obs, 40'd0);
        tick();
        tick();
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (obs != 40'd0) cnt++;
        end
        chk("rst_dropped", 40'(cnt), 40'd0);
        req_cmd = 16'h1111;
        tick();
        chk("rst_ptr", {37'd0, add_vld, add_sel}, {37'd0, 1'b1, 2'd0});
        req_cmd = '0;

        // Randomized requesters against the reference model
        do_reset();
        for (int i = 0; i < 16; i++) busy_until[i] = -1;
        for (int i = 0; i < NQ; i++) begin aq[i] = '0; sq[i] = '0; end
        for (int p = 0; p < 4; p++) begin rc[p] = '0; rt[p] = '0; end
        ptr_a = 0; ptr_s = 0; ack_prev = '0;
        for (int k = 0; k < 2000; k++) begin
            int ba, bs, da, ds, d;
            logic [3:0] inv, ack;
            logic [7:0] itag;
            logic [4:0] ao, so;
            logic [3:0] acmd, scmd;
            for (int p = 0; p < 4; p++) begin
                req_cmd[4*p +: 4] = rc[p];
                req_tag[2*p +: 2] = rt[p];
            end
            ba = -1; bs = -1; da = 9; ds = 9; inv = '0; itag = '0;
            for (int p = 0; p < 4; p++) begin
                int c;
                c = cls_of(rc[p]);
                if (!ack_prev[p]) begin
                    d = (p - ptr_a + 4) % 4;
                    if (c == 1 && k > busy_until[p*4 + int'(rt[p])] && d < da) begin da = d; ba = p; end
                    d = (p - ptr_s + 4) % 4;
                    if (c == 2 && k > busy_until[p*4 + int'(rt[p])] && d < ds) begin ds = d; bs = p; end
                    if (c == 3) begin inv[p] = 1'b1; itag[2*p +: 2] = rt[p]; end
                end
            end
            ack = inv;
            acmd = '0; scmd = '0;
            if (ba >= 0) begin
                ack[ba] = 1'b1;
                acmd = rc[ba];
                busy_until[ba*4 + int'(rt[ba])] = k + 1 + L;
                aq[(k + L) % NQ] = {1'b1, 2'(ba), rt[ba]};
                ptr_a = (ba + 1) % 4;
            end
            if (bs >= 0) begin
                ack[bs] = 1'b1;
                scmd = rc[bs];
                busy_until[bs*4 + int'(rt[bs])] = k + 1 + L;
                sq[(k + L) % NQ] = {1'b1, 2'(bs), rt[bs]};
                ptr_s = (bs + 1) % 4;
            end
            ao = aq[k % NQ]; aq[k % NQ] = '0;
            so = sq[k % NQ]; sq[k % NQ] = '0;
            tick();
            chk($sformatf("rand_k%0d", k), obs,
                pk(ba >= 0, acmd, (ba >= 0) ? 2'(ba) : 2'd0, bs >= 0, scmd, (bs >= 0) ? 2'(bs) : 2'd0,
                   ack, inv, itag, ao[4], ao[3:0], so[4], so[3:0]));
            ack_prev = ack;
            for (int p = 0; p < 4; p++) begin
                if (ack[p] || rc[p] == 4'd0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2: rc[p] = 4'd0;
                        3:       rc[p] = 4'd1;
                        4:       rc[p] = 4'd2;
                        5:       rc[p] = 4'd5;
                        6:       rc[p] = 4'd6;
                        7:       rc[p] = 4'hF;
                        8:       rc[p] = 4'd3;
                        default: rc[p] = 4'($urandom_range(0, 15));
                    endcase
                    rt[p] = 2'($urandom_range(0, 3));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
